// File: rtl/mitchell_pkg.sv
// Shared widths and stage payload for the Mitchell log-multiplier scheduler.
// Operand, mantissa and requester sizes are fixed here for the whole slice.
package mitchell_pkg;

    localparam int N        = 8;
    localparam int LOG_N    = 3;
    localparam int K        = 5;
    localparam int NREQ     = 2;
    localparam int LOG_NREQ = 1;

    localparam int CHAR_W  = LOG_N + 1;
    localparam int LOG_W   = LOG_N + K + 1;
    localparam int Z_W     = 2 * N;
    // Room for {1,mant} shifted by the largest characteristic a CHAR_W field can hold.
    localparam int SHIFT_W = K + (1 << CHAR_W);

    typedef struct packed {
        logic                valid;
        logic [LOG_NREQ-1:0] id;
        logic                zero;
        logic [LOG_W-1:0]    logVal;
    } stage_t;

endpackage

// File: rtl/mitchell_encoder_k.sv
// Mitchell log encoder: leading-one position plus the K truncated bits below it.
// Purely combinational; a zero operand yields charac=0, mant=0 and is flagged upstream.
module mitchell_encoder_k
    import mitchell_pkg::*;
(
    input  logic [N-1:0]     operand,
    output logic [LOG_N-1:0] charac,
    output logic [K-1:0]     mant
);

    always_comb begin
        charac = '0;
        for (int i = 0; i < N; i++) begin
            if (operand[i]) charac = LOG_N'(i);
        end
    end

    // Move the leading one to bit N-1, then keep the K bits right beneath it.
    assign mant = K'((operand << (LOG_N'(N - 1) - charac)) >> (N - 1 - K));

endmodule

// File: rtl/mitchell_mult_scheduler.sv
// Round-robin scheduler feeding one 3-stage Mitchell multiplier (encode, add, decode).
// The whole pipeline freezes while a presented result is not taken.
module mitchell_mult_scheduler
    import mitchell_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ*N-1:0]   req_a,
    input  logic [NREQ*N-1:0]   req_b,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [Z_W-1:0]      res_z,
    output logic [LOG_NREQ-1:0] res_id
);

    // Handshake: a request transfers when req_valid[i] && req_ready[i] at a rising edge;
    // a requester holds valid and operands until then. res_valid, res_z, res_id stay
    // stable until res_valid && res_ready, which is when the result is consumed.

    logic [1:0]          syncFf;
    logic                rstDone;
    logic                stall;
    logic                accept;
    logic                found;
    logic [LOG_NREQ-1:0] ptr;
    logic [LOG_NREQ-1:0] scanIdx;
    logic [LOG_NREQ-1:0] grantIdx;
    logic [NREQ-1:0]     grantVec;
    logic [N-1:0]        opA;
    logic [N-1:0]        opB;
    logic [LOG_N-1:0]    charA;
    logic [LOG_N-1:0]    charB;
    logic [K-1:0]        mantA;
    logic [K-1:0]        mantB;
    stage_t              s1;
    logic [LOG_W-1:0]    s1LogB;
    stage_t              s2;
    logic [CHAR_W-1:0]   decChar;
    logic [SHIFT_W-1:0]  shifted;
    logic [Z_W-1:0]      decZ;

    // Release is synchronised so no request is taken on a partial reset edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) syncFf <= '0;
        else        syncFf <= {syncFf[0], 1'b1};
    end

    assign rstDone = syncFf[1];
    assign stall   = res_valid && !res_ready;

    always_comb begin
        found    = 1'b0;
        grantIdx = ptr;
        scanIdx  = '0;
        for (int off = 0; off < NREQ; off++) begin
            scanIdx = ptr + LOG_NREQ'(off);
            if (!found && req_valid[scanIdx]) begin
                found    = 1'b1;
                grantIdx = scanIdx;
            end
        end
    end

    assign grantVec  = found ? (NREQ'(1) << grantIdx) : '0;
    assign accept    = found && rstDone && !stall;
    assign req_ready = accept ? grantVec : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      ptr <= '0;
        else if (accept) ptr <= grantIdx + LOG_NREQ'(1);
    end

    assign opA = req_a[grantIdx*N +: N];
    assign opB = req_b[grantIdx*N +: N];

    mitchell_encoder_k encA (.operand(opA), .charac(charA), .mant(mantA));
    mitchell_encoder_k encB (.operand(opB), .charac(charB), .mant(mantB));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1     <= '0;
            s1LogB <= '0;
        end else if (!stall) begin
            s1.valid <= accept;
            if (accept) begin
                s1.id     <= grantIdx;
                s1.zero   <= (opA == '0) || (opB == '0);
                s1.logVal <= {1'b0, charA, mantA};
                s1LogB    <= {1'b0, charB, mantB};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2 <= '0;
        end else if (!stall) begin
            s2.valid  <= s1.valid;
            s2.id     <= s1.id;
            s2.zero   <= s1.zero;
            s2.logVal <= s1.logVal + s1LogB;
        end
    end

    // Antilog: {1,mant} scaled by 2^(charac-K); low bits fall off for small characteristics.
    assign decChar = s2.logVal[LOG_W-1:K];
    assign shifted = {{(SHIFT_W-K-1){1'b0}}, 1'b1, s2.logVal[K-1:0]} << decChar;
    assign decZ    = s2.zero ? '0 : Z_W'(shifted >> K);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid <= 1'b0;
            res_z     <= '0;
            res_id    <= '0;
        end else if (!stall) begin
            res_valid <= s2.valid;
            res_z     <= decZ;
            res_id    <= s2.id;
        end
    end

endmodule

// File: tb/tb_mitchell_mult_scheduler.sv
// Scoreboard bench for mitchell_mult_scheduler: arithmetic Mitchell model, round-robin
// model, latency/backpressure/reset checks, and random traffic.
module tb_mitchell_mult_scheduler;
    import mitchell_pkg::*;

    localparam int W = LOG_NREQ + Z_W;

    logic                clk;
    logic                rst_n;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*N-1:0]   req_a;
    logic [NREQ*N-1:0]   req_b;
    logic                res_valid;
    logic                res_ready;
    logic [Z_W-1:0]      res_z;
    logic [LOG_NREQ-1:0] res_id;

    logic [N-1:0] drvA [NREQ];
    logic [N-1:0] drvB [NREQ];

    logic [W-1:0] exp_q[$];
    int           base_q[$];
    int           grant_log[$];

    int errors;
    int checks;
    int cyc;
    int stall_cnt;
    int ptr_model;
    int sync_cnt;
    int exp_grant;

    logic [NREQ-1:0]     last_acc;
    logic [NREQ-1:0]     prev_wait;
    logic [N-1:0]        prev_a [NREQ];
    logic [N-1:0]        prev_b [NREQ];
    logic                prev_stall;
    logic                stall_now;
    logic [Z_W-1:0]      prev_z;
    logic [LOG_NREQ-1:0] prev_id;
    logic [W-1:0]        popped;

    mitchell_mult_scheduler dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_z(res_z), .res_id(res_id)
    );

    always_comb begin
        req_a = '0;
        req_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*N +: N] = drvA[i];
            req_b[i*N +: N] = drvB[i];
        end
    end

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)           sync_cnt <= 0;
        else if (sync_cnt < 2) sync_cnt <= sync_cnt + 1;
    end

    // ---------------- reference model ----------------
    function automatic int log_of(int x);
        int k;
        k = 0;
        while ((x >> (k + 1)) != 0) k++;
        return (k << K) + (((x - (1 << k)) << K) >> k);
    endfunction

    function automatic int mitchell_ref(int a, int b);
        int s;
        if (a == 0 || b == 0) return 0;
        s = log_of(a) + log_of(b);
        return (((1 << K) + (s % (1 << K))) << (s / (1 << K))) >> K;
    endfunction

    function automatic int rr_pick(logic [NREQ-1:0] v, int p);
        for (int o = 0; o < NREQ; o++) begin
            if (v[(p + o) % NREQ]) return (p + o) % NREQ;
        end
        return -1;
    endfunction

    task automatic check(string name, longint got, longint expv);
        checks++;
        if (got != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, expv, cyc);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            base_q.delete();
            ptr_model  = 0;
            last_acc   = '0;
            prev_wait  = '0;
            prev_stall = 1'b0;
            check("reset_res_valid", res_valid, 0);
            check("reset_req_ready", req_ready, 0);
            check("reset_res_z", res_z, 0);
            check("reset_res_id", res_id, 0);
        end else begin
            stall_now = res_valid && !res_ready;
            if (prev_stall) begin
                check("stall_hold_valid", res_valid, 1);
                check("stall_hold_z", res_z, prev_z);
                check("stall_hold_id", res_id, prev_id);
            end
            for (int i = 0; i < NREQ; i++) begin
                if (prev_wait[i]) begin
                    check("req_valid_dropped", req_valid[i], 1);
                    check("req_a_changed", req_a[i*N +: N], prev_a[i]);
                    check("req_b_changed", req_b[i*N +: N], prev_b[i]);
                end
            end
            if (res_valid && !prev_stall) begin
                if (base_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got id=%0d z=%0d expected no result (cycle %0d)", res_id, res_z, cyc);
                end else begin
                    check("latency", cyc, base_q[0] + stall_cnt);
                end
            end
            if (res_valid && res_ready && exp_q.size() != 0) begin
                popped = exp_q.pop_front();
                void'(base_q.pop_front());
                check("result_id_z", {res_id, res_z}, popped);
            end
            exp_grant = (sync_cnt >= 2 && !stall_now) ? rr_pick(req_valid, ptr_model) : -1;
            check("req_ready", req_ready, (exp_grant >= 0) ? (1 << exp_grant) : 0);
            if (exp_grant >= 0) begin
                exp_q.push_back({LOG_NREQ'(exp_grant),
                                 Z_W'(mitchell_ref(int'(req_a[exp_grant*N +: N]),
                                                   int'(req_b[exp_grant*N +: N])))});
                base_q.push_back(cyc + 3 - stall_cnt);
                grant_log.push_back(exp_grant);
                ptr_model = (exp_grant + 1) % NREQ;
            end
            last_acc   = req_valid & req_ready;
            prev_wait  = req_valid & ~req_ready;
            prev_stall = stall_now;
            prev_z     = res_z;
            prev_id    = res_id;
            for (int i = 0; i < NREQ; i++) begin
                prev_a[i] = req_a[i*N +: N];
                prev_b[i] = req_b[i*N +: N];
            end
            if (stall_now) stall_cnt++;
        end
        cyc++;
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_check(int id, int a, int b, int exp_z);
        bit got;
        bit seen;
        tick();
        drvA[id] = N'(a);
        drvB[id] = N'(b);
        req_valid[id] = 1'b1;
        got = 0;
        for (int t = 0; t < 20 && !got; t++) begin
            tick();
            if (last_acc[id]) got = 1;
        end
        req_valid[id] = 1'b0;
        check("issue_accepted", got, 1);
        seen = 0;
        for (int t = 0; t < 20 && !seen; t++) begin
            @(negedge clk);
            if (res_valid) begin
                seen = 1;
                check("direct_z", res_z, exp_z);
                check("direct_id", res_id, id);
            end
        end
        check("direct_result_seen", seen, 1);
    endtask

    // Both requesters stream; accepted ones reload, and after n_acc accepts each drops
    // only once it has been accepted.
    task automatic stream(int n_acc, int stall_at, int stall_len);
        int  cnt;
        int  stall_left;
        bit  stall_done;
        cnt = 0;
        stall_left = 0;
        stall_done = 0;
        tick();
        for (int i = 0; i < NREQ; i++) begin
            drvA[i] = N'($urandom_range(0, 255));
            drvB[i] = N'($urandom_range(0, 255));
        end
        req_valid = '1;
        for (int t = 0; t < 200 && req_valid != '0; t++) begin
            tick();
            for (int i = 0; i < NREQ; i++) begin
                if (last_acc[i]) begin
                    cnt++;
                    if (cnt >= n_acc) begin
                        req_valid[i] = 1'b0;
                    end else begin
                        drvA[i] = N'($urandom_range(0, 255));
                        drvB[i] = N'($urandom_range(0, 255));
                    end
                end
            end
            if (stall_left > 0) begin
                stall_left--;
                if (stall_left == 0) res_ready = 1'b1;
            end else if (!stall_done && cnt == stall_at) begin
                res_ready  = 1'b0;
                stall_left = stall_len;
                stall_done = 1;
            end
        end
        check("stream_finished", req_valid, 0);
        res_ready = 1'b1;
    endtask

    task automatic reset_midstream();
        int cnt;
        cnt = 0;
        tick();
        for (int i = 0; i < NREQ; i++) begin
            drvA[i] = N'($urandom_range(1, 255));
            drvB[i] = N'($urandom_range(1, 255));
        end
        req_valid = '1;
        for (int t = 0; t < 50 && cnt < 3; t++) begin
            tick();
            for (int i = 0; i < NREQ; i++) begin
                if (last_acc[i]) begin
                    cnt++;
                    drvA[i] = N'($urandom_range(1, 255));
                    drvB[i] = N'($urandom_range(1, 255));
                end
            end
        end
        check("pre_reset_res_valid", res_valid, 1);
        #1;
        rst_n = 1'b0;
        req_valid = '0;
        #1;
        check("async_reset_res_valid", res_valid, 0);
        check("async_reset_req_ready", req_ready, 0);
        @(negedge clk);
        tick();
        rst_n = 1'b1;
    endtask

    task automatic random_phase(int cycles);
        for (int t = 0; t < cycles; t++) begin
            tick();
            res_ready = ($urandom_range(0, 9) < 7);
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] || last_acc[i]) begin
                    req_valid[i] = ($urandom_range(0, 2) != 0);
                    drvA[i] = ($urandom_range(0, 7) == 0) ? '0 : N'($urandom_range(1, 255));
                    drvB[i] = ($urandom_range(0, 7) == 0) ? 8'd255 : N'($urandom_range(0, 255));
                end
            end
        end
        res_ready = 1'b1;
        for (int t = 0; t < 50 && req_valid != '0; t++) begin
            tick();
            req_valid = req_valid & ~last_acc;
        end
        check("random_drained", req_valid, 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int gl;
        errors    = 0;
        checks    = 0;
        cyc       = 0;
        stall_cnt = 0;
        ptr_model = 0;
        rst_n     = 1'b0;
        res_ready = 1'b1;
        req_valid = '0;
        for (int i = 0; i < NREQ; i++) begin
            drvA[i] = '0;
            drvB[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) tick();

        issue_check(0, 8, 8, 64);
        issue_check(0, 3, 3, 8);
        issue_check(0, 1, 1, 1);
        issue_check(0, 255, 255, 63488);
        issue_check(0, 0, 200, 0);
        issue_check(1, 2, 5, 10);

        gl = grant_log.size();
        stream(6, -1, 0);
        check("alt_grants_count", (grant_log.size() - gl >= 6), 1);
        if (grant_log.size() - gl >= 6) begin
            for (int k = 0; k < 6; k++) check("alt_grant_order", grant_log[gl + k], k % 2);
        end
        repeat (6) tick();

        stream(8, 4, 4);
        repeat (8) tick();

        reset_midstream();
        repeat (5) tick();
        check("post_reset_queue_empty", exp_q.size(), 0);
        gl = grant_log.size();
        stream(2, -1, 0);
        check("post_reset_grants", (grant_log.size() > gl), 1);
        if (grant_log.size() > gl) check("post_reset_first_grant", grant_log[gl], 0);
        repeat (6) tick();

        random_phase(300);

        res_ready = 1'b1;
        for (int t = 0; t < 20 && exp_q.size() != 0; t++) tick();
        check("final_queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
